sudoku_rand_gen: RTL and testbench
==================================

Name: sudoku_rand_gen

Overview:
- Upstream random-source stage for the Sudoku game FSM; produces the `rand_setup`, `rand_A` and `rand_B` values the FSM consumes when it generates a new puzzle.
- Contains a free-running 16-bit LFSR, so the timing of user button presses provides entropy.
- A small draw FSM uses rejection sampling to produce an in-range setup index and two distinct swap indices A and B.
- Results are offered on a valid/ack handshake.

Parameters:
- SEED, 16'hACE1, LFSR value loaded at reset, or when a zero seed is presented on reseed.
- SETUP_MAX, 15, largest accepted out_rand_setup value (0..15).
- AB_MAX, 3, largest accepted A/B value. Must be >=1.
- MAX_TRIES, 8, rejections allowed per draw state before the fallback value is used. Must be >=1.

Ports:
- in_clk  input  1  single clock, rising edge.
- in_restart_n  input  1  asynchronous active-low reset.
- in_req  input  1  request pulse from the game FSM to draw a new triple.
- in_ack  input  1  consumer has taken the presented triple.
- in_reseed  input  1  load in_seed into the LFSR this cycle.
- in_seed  input  16  reseed value.
- out_busy  output  1  high while a draw is in progress (states S, A, B).
- out_valid  output  1  triple is valid and held until acked.
- out_rand_setup  output  4  drawn setup index.
- out_rand_A  output  4  drawn swap index A.
- out_rand_B  output  4  drawn swap index B, always != A when valid.

Behaviour:
- Reset (async, in_restart_n=0):
  - LFSR is loaded with SEED.
  - State is IDLE and the retry counter is 0.
  - out_busy=0, out_valid=0, out_rand_setup=out_rand_A=out_rand_B=0.
- LFSR:
  - Fibonacci, left shift: next = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
  - Advances on every clock edge in every state.
  - When in_reseed=1, the LFSR loads in_seed (or SEED if in_seed==0) instead of advancing. Reseed wins over advance.
  - Reseed does not disturb the FSM.
  - The LFSR is never zero.
- Draw nibble: n = current l[3:0], sampled at the edge that evaluates the draw state.
- States and transitions:
  - IDLE: if in_req=1, go to S and clear the retry counter. Otherwise stay.
  - S: if n<=SETUP_MAX, setup<=n and go to A.
  - A: if n<=AB_MAX, A<=n and go to B.
  - B: if n<=AB_MAX and n!=A, B<=n and go to VALID.
  - VALID: out_valid=1 and all outputs are held stable. If in_ack=1, go to IDLE.
- Rejection in S, A or B: stay in the state and increment the retry counter.
- Fallback: when a rejection would occur with retry counter==MAX_TRIES-1, use the fallback value and advance as if accepted.
  - Setup fallback: 0.
  - A fallback: 0.
  - B fallback: A+1 if A<AB_MAX, else 0.
- The retry counter clears on every state advance.
- out_busy=1 exactly in S, A and B. out_busy and out_valid are never both 1.
- Latency:
  - Minimum: out_valid rises 3 edges after the edge that samples in_req.
  - Maximum: 3*MAX_TRIES edges.
- in_req while busy or in VALID is ignored; it is not queued.
- in_ack outside VALID is ignored.
- Simultaneous in_ack and in_req in VALID: go to IDLE; that in_req is dropped.
- Outputs out_rand_* keep their last drawn values in IDLE. They update only at the accepting edge of their own state.
- Reset asserted mid-draw aborts immediately to the reset values; no partial result is ever presented.

Test Plan:
- Reset check: hold in_restart_n=0, then release → out_busy=0, out_valid=0, all out_rand_*=0. Advance 16 cycles → outputs unchanged.
- Basic draw: in_reseed=1 with in_seed=16'h0000 → LFSR equals 16'hACE1. Then pulse in_req.
  - out_busy=1 within 1 edge; out_valid within 3..24 edges.
  - out_rand_setup<=15, out_rand_A<=3, out_rand_B<=3, A!=B.
  - Outputs stable until in_ack.
- Handshake:
  - Hold in_ack=0 for 20 cycles in VALID → out_valid stays 1 with no value change.
  - in_ack=1 with in_req=1 in the same cycle → IDLE next cycle, no new draw.
  - A later in_req starts a new draw.
- Busy ignore: pulse in_req again during S/A/B → exactly one VALID episode results, and no second draw after ack.
- Fallback path (AB_MAX=1, MAX_TRIES=1): 200 requests → every result has {A,B} in {(0,1),(1,0)} and latency is exactly 3 edges each time.
- Reset mid-operation: assert in_restart_n=0 while in state B → out_busy=0, out_valid=0, outputs=0 asynchronously. After release, LFSR=16'hACE1.

Source files
------------

// File: rtl/sudoku_rand_gen.sv
// Random-source stage for the Sudoku game FSM: free-running LFSR plus a draw FSM
// that rejection-samples a setup index and two distinct swap indices A/B.
//
// state | meaning
// IDLE  | waiting for in_req
// S     | drawing the setup index
// A     | drawing swap index A
// B     | drawing swap index B (must differ from A)
// VALID | triple presented, held until in_ack
module sudoku_rand_gen #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          SETUP_MAX = 15,
    parameter int          AB_MAX    = 3,
    parameter int          MAX_TRIES = 8
) (
    input  logic        in_clk,
    input  logic        in_restart_n,
    input  logic        in_req,
    input  logic        in_ack,
    input  logic        in_reseed,
    input  logic [15:0] in_seed,
    output logic        out_busy,
    output logic        out_valid,
    output logic [3:0]  out_rand_setup,
    output logic [3:0]  out_rand_A,
    output logic [3:0]  out_rand_B
);

    localparam int CNT_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_TRIES - 1);
    // Limits compared at 5 bits so a limit of 15 is not a constant-true compare.
    localparam logic [4:0] SETUP_LIM = 5'(SETUP_MAX);
    localparam logic [4:0] AB_LIM    = 5'(AB_MAX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S     = 3'd1,
        ST_A     = 3'd2,
        ST_B     = 3'd3,
        ST_VALID = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_next;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [3:0]       setup_q, setup_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [3:0]       nib;
    logic [4:0]       nib_w;
    logic             last_try;
    logic [3:0]       b_fallback;

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Reseed takes priority over advancing; a zero seed would lock the LFSR up.
    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            lfsr_q <= SEED;
        end else if (in_reseed) begin
            lfsr_q <= (in_seed == 16'h0000) ? SEED : in_seed;
        end else begin
            lfsr_q <= lfsr_next;
        end
    end

    assign nib        = lfsr_q[3:0];
    assign nib_w      = {1'b0, nib};
    assign last_try   = (retry_q == LAST_TRY);
    assign b_fallback = ({1'b0, a_q} < AB_LIM) ? (a_q + 4'd1) : 4'd0;

    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            setup_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            setup_q <= setup_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        setup_d = setup_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (in_req) begin
                    state_d = ST_S;
                    retry_d = '0;
                end
            end
            ST_S: begin
                if (nib_w <= SETUP_LIM) begin
                    setup_d = nib;
                    state_d = ST_A;
                    retry_d = '0;
                end else if (last_try) begin
                    setup_d = 4'd0;
                    state_d = ST_A;
                    retry_d = '0;
                end else begin
                    retry_d = retry_q + CNT_W'(1);
                end
            end
            ST_A: begin
                if (nib_w <= AB_LIM) begin
                    a_d     = nib;
                    state_d = ST_B;
                    retry_d = '0;
                end else if (last_try) begin
                    a_d     = 4'd0;
                    state_d = ST_B;
                    retry_d = '0;
                end else begin
                    retry_d = retry_q + CNT_W'(1);
                end
            end
            ST_B: begin
                if ((nib_w <= AB_LIM) && (nib != a_q)) begin
                    b_d     = nib;
                    state_d = ST_VALID;
                    retry_d = '0;
                end else if (last_try) begin
                    b_d     = b_fallback;
                    state_d = ST_VALID;
                    retry_d = '0;
                end else begin
                    retry_d = retry_q + CNT_W'(1);
                end
            end
            ST_VALID: begin
                // A coincident in_req is intentionally dropped here.
                if (in_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                retry_d = '0;
            end
        endcase
    end

    assign out_busy       = (state_q == ST_S) || (state_q == ST_A) || (state_q == ST_B);
    assign out_valid      = (state_q == ST_VALID);
    assign out_rand_setup = setup_q;
    assign out_rand_A     = a_q;
    assign out_rand_B     = b_q;

endmodule

// File: tb/tb_sudoku_rand_gen.sv
// Scoreboard bench for sudoku_rand_gen: a reference LFSR and draw model predict each
// triple and its latency when the request is driven; results are popped on out_valid.
module tb_sudoku_rand_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, ack, req_fb, ack_fb, reseed;
    logic [15:0] seed;

    logic       busy, valid, busy_fb, valid_fb;
    logic [3:0] r_setup, r_a, r_b, r_setup_fb, r_a_fb, r_b_fb;

    logic       use_fb;
    logic       o_busy, o_valid;
    logic [3:0] o_setup, o_a, o_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int setup;
        int a;
        int b;
        int lat;
        int to_b;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_e;
    logic [15:0] shadow;

    always #5 clk = ~clk;

    sudoku_rand_gen dut (
        .in_clk(clk), .in_restart_n(rst_n), .in_req(req), .in_ack(ack),
        .in_reseed(reseed), .in_seed(seed),
        .out_busy(busy), .out_valid(valid),
        .out_rand_setup(r_setup), .out_rand_A(r_a), .out_rand_B(r_b)
    );

    sudoku_rand_gen #(.AB_MAX(1), .MAX_TRIES(1)) dut_fb (
        .in_clk(clk), .in_restart_n(rst_n), .in_req(req_fb), .in_ack(ack_fb),
        .in_reseed(reseed), .in_seed(seed),
        .out_busy(busy_fb), .out_valid(valid_fb),
        .out_rand_setup(r_setup_fb), .out_rand_A(r_a_fb), .out_rand_B(r_b_fb)
    );

    assign o_busy  = use_fb ? busy_fb    : busy;
    assign o_valid = use_fb ? valid_fb   : valid;
    assign o_setup = use_fb ? r_setup_fb : r_setup;
    assign o_a     = use_fb ? r_a_fb     : r_a;
    assign o_b     = use_fb ? r_b_fb     : r_b;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      shadow <= 16'hACE1;
        else if (reseed) shadow <= (seed == 16'h0000) ? 16'hACE1 : seed;
        else             shadow <= step(shadow);
    end

    // l0 is the LFSR value at the edge that samples in_req.
    function automatic exp_t predict(input logic [15:0] l0, input int ab_max, input int max_tries);
        exp_t        e;
        logic [15:0] v;
        int          n, tries, val;
        bit          done, ok;
        v = step(l0);
        e.setup = 0; e.a = 0; e.b = 0; e.lat = 0; e.to_b = 0;
        for (int st = 0; st < 3; st++) begin
            tries = 0;
            done  = 0;
            if (st == 2) e.to_b = e.lat;
            while (!done) begin
                n = int'(v[3:0]);
                v = step(v);
                e.lat++;
                if (st == 0)      ok = (n <= 15);
                else if (st == 1) ok = (n <= ab_max);
                else              ok = (n <= ab_max) && (n != e.a);
                val = 0;
                if (ok) val = n;
                else if (st == 2) val = (e.a < ab_max) ? e.a + 1 : 0;
                if (ok || tries == max_tries - 1) begin
                    done = 1;
                    if (st == 0)      e.setup = val;
                    else if (st == 1) e.a = val;
                    else              e.b = val;
                end else begin
                    tries++;
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request on the selected instance and waits for out_valid (no ack).
    task automatic do_draw(input bit extra_req, output int lat);
        exp_t e;
        int   mt;
        mt = use_fb ? 1 : 8;
        sb_q.push_back(predict(shadow, use_fb ? 1 : 3, mt));
        if (use_fb) req_fb = 1'b1; else req = 1'b1;
        tick();
        req = 1'b0; req_fb = 1'b0;
        chk("busy_after_req", 32'(o_busy), 32'd1);
        chk("no_valid_when_busy", 32'(o_valid), 32'd0);
        lat = 0;
        while (!o_valid && lat < 3 * mt + 4) begin
            if (extra_req && lat == 0) begin
                if (use_fb) req_fb = 1'b1; else req = 1'b1;
            end
            tick();
            req = 1'b0; req_fb = 1'b0;
            lat++;
        end
        chk("valid_seen", 32'(o_valid), 32'd1);
        chk("busy_low_in_valid", 32'(o_busy), 32'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            last_e = e;
            chk("latency", 32'(lat), 32'(e.lat));
            chk("setup", 32'(o_setup), 32'(e.setup));
            chk("rand_a", 32'(o_a), 32'(e.a));
            chk("rand_b", 32'(o_b), 32'(e.b));
        end else begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end
        chk("a_ne_b", 32'(o_a != o_b), 32'd1);
        chk("a_range", 32'(o_a <= (use_fb ? 4'd1 : 4'd3)), 32'd1);
        chk("b_range", 32'(o_b <= (use_fb ? 4'd1 : 4'd3)), 32'd1);
        chk("lat_range", 32'(lat >= 3 && lat <= 3 * mt), 32'd1);
    endtask

    task automatic do_ack();
        if (use_fb) ack_fb = 1'b1; else ack = 1'b1;
        tick();
        ack = 1'b0; ack_fb = 1'b0;
        chk("idle_after_ack", 32'(o_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] seeds[4];
        int          lat;
        int          extra_busy;
        exp_t        e;
        seeds[0] = 16'h1234; seeds[1] = 16'hBEEF; seeds[2] = 16'h0001; seeds[3] = 16'hFFFF;
        rst_n = 1'b0; req = 1'b0; ack = 1'b0; req_fb = 1'b0; ack_fb = 1'b0;
        reseed = 1'b0; seed = 16'h0000; use_fb = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_setup", 32'(r_setup), 32'd0);
        chk("rst_a", 32'(r_a), 32'd0);
        chk("rst_b", 32'(r_b), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        rst_n = 1'b1;
        repeat (16) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_outs", 32'({r_setup, r_a, r_b}), 32'd0);
        chk("lfsr_track", 32'(dut.lfsr_q), 32'(shadow));

        // Zero seed reloads the default seed.
        seed = 16'h0000; reseed = 1'b1;
        tick();
        reseed = 1'b0;
        chk("reseed_zero", 32'(dut.lfsr_q), 32'h0000ACE1);

        do_draw(1'b0, lat);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", 32'(valid), 32'd1);
            chk("hold_vals", 32'({r_setup, r_a, r_b}), 32'({4'(last_e.setup), 4'(last_e.a), 4'(last_e.b)}));
        end

        // Ack and req together: the req is dropped.
        ack = 1'b1; req = 1'b1;
        tick();
        ack = 1'b0; req = 1'b0;
        chk("ackreq_valid", 32'(valid), 32'd0);
        chk("ackreq_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("ackreq_no_draw", 32'(busy | valid), 32'd0);
        chk("idle_keeps_vals", 32'({r_setup, r_a, r_b}), 32'({4'(last_e.setup), 4'(last_e.a), 4'(last_e.b)}));

        do_draw(1'b0, lat);
        do_ack();

        // Second request while busy must not queue.
        do_draw(1'b1, lat);
        do_ack();
        extra_busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || valid) extra_busy++;
        end
        chk("no_second_draw", 32'(extra_busy), 32'd0);

        foreach (seeds[k]) begin
            seed = seeds[k]; reseed = 1'b1;
            tick();
            reseed = 1'b0;
            chk("reseed_val", 32'(dut.lfsr_q), 32'(seeds[k]));
            do_draw(1'b0, lat);
            do_ack();
            repeat (k + 1) tick();
        end

        use_fb = 1'b1;
        for (int i = 0; i < 200; i++) begin
            do_draw(1'b0, lat);
            chk("fb_pair", 32'((r_a_fb == 4'd0 && r_b_fb == 4'd1) || (r_a_fb == 4'd1 && r_b_fb == 4'd0)), 32'd1);
            chk("fb_lat", 32'(lat), 32'd3);
            do_ack();
            repeat (i % 3) tick();
        end
        use_fb = 1'b0;

        // Reset while the main instance is drawing B.
        e = predict(shadow, 3, 8);
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (e.to_b) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_outs", 32'({r_setup, r_a, r_b}), 32'd0);
        #4 rst_n = 1'b1;
        #1;
        chk("post_rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
        tick();
        chk("post_rst_idle", 32'(busy | valid), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
